rv32i_csr_irq: RTL

Parametrised machine-mode CSR file with 64-bit hardware counters, interrupt pending/enable logic and vectored trap support. It is the CSR block of the RV32I core pipeline: the core reads and writes it in the execute stage, reports exceptions, retirements and MRET to it, and gets the trap target PC, MRET return PC and an interrupt request back from it. The block owns the cycle and instret counters itself instead of shadowing external counts.

---
 rtl/rv32_csr_pkg.sv | 59 +++++
 rtl/rv32_csr_counter.sv | 38 +++
 rtl/rv32i_csr_irq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_csr_pkg.sv
// Shared definitions for the RV32I machine-mode CSR block: addresses, op encodings,
// register bit positions, interrupt causes and constant register values.
package rv32_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MEDELEG       = 12'h302;
    localparam logic [11:0] CSR_MIDELEG       = 12'h303;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_SATP          = 12'h180;
    localparam logic [11:0] CSR_PMPCFG0       = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0      = 12'h3B0;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned IRQ_MSI_BIT      = 3;
    localparam int unsigned IRQ_MTI_BIT      = 7;
    localparam int unsigned IRQ_MEI_BIT      = 11;

    localparam logic [31:0] MIE_MASK           = 32'h0000_0888;
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/rv32_csr_counter.sv
// Hardware counter (mcycle/minstret) with independently writable 32-bit halves.
module rv32_csr_counter
    import rv32_csr_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_i,
    input  logic                     inhibit_i,
    input  logic                     wr_lo_i,
    input  logic                     wr_hi_i,
    input  logic [31:0]              wdata_i,
    output logic [COUNTER_WIDTH-1:0] count_o
);

    logic [COUNTER_WIDTH-1:0] count_q, count_d;

    // Any write suppresses this cycle's increment; the unwritten half holds its value.
    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0] = wdata_i;
            if (wr_hi_i && COUNTER_WIDTH == 64)
                count_d[COUNTER_WIDTH-1:COUNTER_WIDTH-32] = wdata_i;
        end else if (inc_i && !inhibit_i) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/rv32i_csr_irq.sv
// Machine-mode CSR file for the RV32I core: WARL registers, counters,
// interrupt pending/priority logic and direct/vectored trap targets.
module rv32i_csr_irq
    import rv32_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID       = 32'd0,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [2:0]  csr_op,
    input  logic        csr_we,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        retire,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    input  logic        exception_trigger,
    input  logic [31:0] exception_cause,
    input  logic [31:0] exception_pc,
    input  logic [31:0] exception_value,
    input  logic        mret_trigger,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);

    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    logic        mie_bit_q, mpie_bit_q;
    logic [31:0] mie_q, mtvec_q, mepc_q, mscratch_q, mcause_q, mtval_q, mcountinhibit_q, mip_q;
    logic [31:0] mstatus, src, wval;
    logic [63:0] cyc64, ins64;
    logic [COUNTER_WIDTH-1:0] cyc_cnt, ins_cnt;
    logic        known, wr_en;

    assign mstatus = {19'b0, 2'b11, 3'b0, mpie_bit_q, 3'b0, mie_bit_q, 3'b0};

    if (COUNTER_WIDTH == 64) begin : g_cnt64
        assign cyc64 = cyc_cnt;
        assign ins64 = ins_cnt;
    end else begin : g_cnt32
        assign cyc64 = {32'b0, cyc_cnt};
        assign ins64 = {32'b0, ins_cnt};
    end

    always_comb begin
        known     = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:                         csr_rdata = mstatus;
            CSR_MISA:                            csr_rdata = MISA_VALUE;
            CSR_MIE:                             csr_rdata = mie_q;
            CSR_MTVEC:                           csr_rdata = mtvec_q;
            CSR_MCOUNTINHIBIT:                   csr_rdata = mcountinhibit_q;
            CSR_MSCRATCH:                        csr_rdata = mscratch_q;
            CSR_MEPC:                            csr_rdata = mepc_q;
            CSR_MCAUSE:                          csr_rdata = mcause_q;
            CSR_MTVAL:                           csr_rdata = mtval_q;
            CSR_MIP:                             csr_rdata = mip_q;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:     csr_rdata = cyc64[31:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:  csr_rdata = cyc64[63:32];
            CSR_MINSTRET, CSR_INSTRET:           csr_rdata = ins64[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:         csr_rdata = ins64[63:32];
            CSR_MHARTID:                         csr_rdata = HART_ID;
            CSR_MEDELEG, CSR_MIDELEG, CSR_SATP, CSR_PMPCFG0, CSR_PMPADDR0,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = '0;
            default:                             known = 1'b0;
        endcase
    end

    assign csr_illegal = !known || (csr_we && csr_addr[11:10] == 2'b11);
    assign wr_en       = csr_we && !csr_illegal && !exception_trigger;

    always_comb begin
        src  = csr_op[2] ? {27'b0, csr_wdata[4:0]} : csr_wdata;
        wval = csr_rdata;
        case (csr_op_e'(csr_op))
            CSR_OP_RW, CSR_OP_RWI: wval = src;
            CSR_OP_RS, CSR_OP_RSI: wval = csr_rdata | src;
            CSR_OP_RC, CSR_OP_RCI: wval = csr_rdata & ~src;
            default:               wval = csr_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_bit_q       <= 1'b0;
            mpie_bit_q      <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= RESET_MTVEC & MTVEC_MASK;
            mepc_q          <= '0;
            mscratch_q      <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
            mip_q           <= '0;
        end else begin
            mip_q <= '0;
            mip_q[IRQ_MSI_BIT] <= irq_software;
            mip_q[IRQ_MTI_BIT] <= irq_timer;
            mip_q[IRQ_MEI_BIT] <= irq_external;
            if (exception_trigger) begin
                mepc_q     <= exception_pc & ~32'd3;
                mcause_q   <= exception_cause;
                mtval_q    <= exception_value;
                mpie_bit_q <= mie_bit_q;
                mie_bit_q  <= 1'b0;
            end else begin
                if (mret_trigger) begin
                    mie_bit_q  <= mpie_bit_q;
                    mpie_bit_q <= 1'b1;
                end else if (wr_en && csr_addr == CSR_MSTATUS) begin
                    mie_bit_q  <= wval[MSTATUS_MIE_BIT];
                    mpie_bit_q <= wval[MSTATUS_MPIE_BIT];
                end
                if (wr_en) begin
                    case (csr_addr)
                        CSR_MIE:           mie_q           <= wval & MIE_MASK;
                        CSR_MTVEC:         mtvec_q         <= wval & MTVEC_MASK;
                        CSR_MCOUNTINHIBIT: mcountinhibit_q <= wval & MCOUNTINHIBIT_MASK;
                        CSR_MSCRATCH:      mscratch_q      <= wval;
                        CSR_MEPC:          mepc_q          <= wval & ~32'd3;
                        CSR_MCAUSE:        mcause_q        <= wval;
                        CSR_MTVAL:         mtval_q         <= wval;
                        default: ;
                    endcase
                end
            end
        end
    end

    rv32_csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (1'b1),
        .inhibit_i (mcountinhibit_q[0]),
        .wr_lo_i   (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi_i   (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata_i   (wval),
        .count_o   (cyc_cnt)
    );

    rv32_csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (retire && !exception_trigger),
        .inhibit_i (mcountinhibit_q[2]),
        .wr_lo_i   (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi_i   (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata_i   (wval),
        .count_o   (ins_cnt)
    );

    logic [31:0] pend;
    assign pend        = mip_q & mie_q;
    assign irq_pending = mie_bit_q && (|pend);

    always_comb begin
        irq_cause = '0;
        if (irq_pending) begin
            if (pend[IRQ_MEI_BIT])      irq_cause = CAUSE_MEI;
            else if (pend[IRQ_MSI_BIT]) irq_cause = CAUSE_MSI;
            else                        irq_cause = CAUSE_MTI;
        end
    end

    always_comb begin
        trap_vector = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && exception_cause[31])
            trap_vector = {mtvec_q[31:2], 2'b00} + {25'b0, exception_cause[4:0], 2'b00};
    end

    assign mepc_out = mepc_q;

endmodule
